// File: rtl/punc_fetch_if.sv
// Memory read port of the PUnC fetch stage: the request/acknowledge handshake.
interface punc_fetch_if;
  localparam int unsigned W = 16;

  logic         mem_req;
  logic [W-1:0] mem_addr;
  logic         mem_ack;
  logic [W-1:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/punc_fetch.sv
// PUnC LC3 instruction-fetch stage: owns PC and IR, issues variable-latency
// memory reads and applies control-unit PC commands.
module punc_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic        halt,
  input  logic        pc_clr,
  input  logic        pc_ld,
  input  logic [15:0] pc_ld_data,
  input  logic        pc_inc,
  punc_fetch_if.master mem,
  output logic [15:0] ir,
  output logic        ir_valid,
  output logic        fetch_done,
  output logic [15:0] pc,
  output logic        busy,
  output logic        halted,
  output logic [15:0] fetch_cnt,
  output logic        err
);
  localparam int unsigned W = 16;
  localparam logic [W-1:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_DONE   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t       state, state_d;
  logic [W-1:0] pc_d, ir_d, addr_q, addr_d, cnt_d;
  logic         ir_valid_d, err_d, pend_q, pend_d;
  logic         pc_cmd;

  // Handshake and status outputs decode straight from the state register.
  assign mem.mem_req  = (state == S_REQ);
  assign mem.mem_addr = addr_q;
  assign fetch_done   = (state == S_DONE);
  assign busy         = (state == S_REQ) || (state == S_DONE);
  assign halted       = (state == S_HALTED);
  assign pc_cmd       = pc_clr || pc_ld || pc_inc;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      ir_valid  <= 1'b0;
      addr_q    <= '0;
      fetch_cnt <= '0;
      err       <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      ir        <= ir_d;
      ir_valid  <= ir_valid_d;
      addr_q    <= addr_d;
      fetch_cnt <= cnt_d;
      err       <= err_d;
      pend_q    <= pend_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    ir_d       = ir;
    ir_valid_d = ir_valid;
    addr_d     = addr_q;
    cnt_d      = fetch_cnt;
    err_d      = err;
    pend_d     = pend_q;

    unique case (state)
      S_IDLE: begin
        if (halt) begin
          state_d = S_HALTED;
        end else if (fetch_req) begin
          state_d    = S_REQ;
          addr_d     = pc;
          ir_valid_d = 1'b0;
        end
      end
      S_REQ: begin
        if (halt)   pend_d = 1'b1;
        if (pc_cmd) err_d  = 1'b1;
        if (mem.mem_ack) begin
          ir_d       = mem.mem_rdata;
          ir_valid_d = 1'b1;
          if (fetch_cnt != CNT_MAX) cnt_d = fetch_cnt + W'(1);
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (halt || pend_q) begin
          state_d = S_HALTED;
          pend_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
    endcase

    // PC commands are only honoured between fetches; clear beats load beats increment.
    if ((state == S_IDLE) || (state == S_DONE)) begin
      if (pc_clr)      pc_d = RESET_PC;
      else if (pc_ld)  pc_d = pc_ld_data;
      else if (pc_inc) pc_d = pc + W'(1);
    end
  end
endmodule

// File: tb/tb_punc_fetch.sv
// Self-checking bench for punc_fetch: PC command table, directed fetch
// sequences and randomized fetch transactions against a transaction model.
module tb_punc_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0, halt = 1'b0;
  logic        pc_clr = 1'b0, pc_ld = 1'b0, pc_inc = 1'b0;
  logic [15:0] pc_ld_data = '0;
  logic [15:0] ir, pc, fetch_cnt;
  logic        ir_valid, fetch_done, busy, halted, err;

  int n_checks = 0;
  int n_fail   = 0;

  punc_fetch_if mif ();

  punc_fetch #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .halt(halt),
    .pc_clr(pc_clr), .pc_ld(pc_ld), .pc_ld_data(pc_ld_data), .pc_inc(pc_inc),
    .mem(mif), .ir(ir), .ir_valid(ir_valid), .fetch_done(fetch_done),
    .pc(pc), .busy(busy), .halted(halted), .fetch_cnt(fetch_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr, ld, inc;
    logic [15:0] data;
    logic [15:0] exp_pc;
  } pc_vec_t;

  pc_vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pc_cmd(input logic c, input logic l, input logic i, input logic [15:0] d);
    pc_clr = c; pc_ld = l; pc_inc = i; pc_ld_data = d;
    tick();
    pc_clr = 0; pc_ld = 0; pc_inc = 0;
  endtask

  // Transaction model: PC rule and fetch count.
  function automatic logic [15:0] model_pc(input logic [15:0] p, input logic c,
                                           input logic l, input logic i, input logic [15:0] d);
    if (c) return 16'h0000;
    if (l) return d;
    if (i) return p + 16'd1;
    return p;
  endfunction

  logic [15:0] m_pc, r, start_addr;
  int          m_cnt;

  initial begin
    vecs[0] = '{0, 1, 0, 16'hFFFF, 16'hFFFF};
    vecs[1] = '{0, 0, 1, 16'h0000, 16'h0000};
    vecs[2] = '{1, 1, 1, 16'h3000, 16'h0000};
    vecs[3] = '{0, 1, 1, 16'h3000, 16'h3000};
    vecs[4] = '{0, 0, 1, 16'h0000, 16'h3001};
    vecs[5] = '{0, 1, 0, 16'h1234, 16'h1234};
    vecs[6] = '{1, 0, 0, 16'h5555, 16'h0000};
    vecs[7] = '{0, 0, 0, 16'h7777, 16'h0000};

    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    tick(); tick();
    check("rst_pc", 32'(pc), 0);
    check("rst_ir", 32'(ir), 0);
    check("rst_ir_valid", 32'(ir_valid), 0);
    check("rst_mem_req", 32'(mif.mem_req), 0);
    check("rst_mem_addr", 32'(mif.mem_addr), 0);
    check("rst_status", {28'd0, fetch_done, busy, halted, err}, 0);
    check("rst_cnt", 32'(fetch_cnt), 0);
    rst_n = 1'b1;
    tick();

    // PC command table in IDLE.
    for (int k = 0; k < 8; k++) begin
      pc_cmd(vecs[k].clr, vecs[k].ld, vecs[k].inc, vecs[k].data);
      check($sformatf("pc_vec%0d", k), 32'(pc), 32'(vecs[k].exp_pc));
    end
    check("pc_vec_err", 32'(err), 0);

    // Fetch with ack on the first REQ cycle.
    fetch_req = 1; tick(); fetch_req = 0;
    check("f1_mem_req", 32'(mif.mem_req), 1);
    check("f1_mem_addr", 32'(mif.mem_addr), 0);
    check("f1_busy", 32'(busy), 1);
    mif.mem_ack = 1; mif.mem_rdata = 16'h1261; tick(); mif.mem_ack = 0;
    check("f1_done", 32'(fetch_done), 1);
    check("f1_ir", 32'(ir), 32'h1261);
    check("f1_ir_valid", 32'(ir_valid), 1);
    check("f1_req_drop", 32'(mif.mem_req), 0);
    check("f1_cnt", 32'(fetch_cnt), 1);
    // PC load accepted in DONE.
    pc_cmd(0, 1, 0, 16'h4000);
    check("f1_done_pulse", 32'(fetch_done), 0);
    check("f1_idle_busy", 32'(busy), 0);
    check("done_pc_ld", 32'(pc), 32'h4000);

    // Delayed ack with toggling read data.
    fetch_req = 1; tick(); fetch_req = 0;
    check("f2_ivalid_clr", 32'(ir_valid), 0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("f2_req_c%0d", k), 32'(mif.mem_req), 1);
      check($sformatf("f2_addr_c%0d", k), 32'(mif.mem_addr), 32'h4000);
      if (k < 5) begin
        mif.mem_rdata = 16'($urandom); tick();
      end
    end
    mif.mem_ack = 1; mif.mem_rdata = 16'hABCD; tick(); mif.mem_ack = 0;
    mif.mem_rdata = 16'h0BAD;
    check("f2_ir", 32'(ir), 32'hABCD);
    check("f2_req_drop", 32'(mif.mem_req), 0);
    check("f2_cnt", 32'(fetch_cnt), 2);
    tick();

    // Randomized fetch transactions.
    m_pc = 16'h4000; m_cnt = 2;
    for (int it = 0; it < 20; it++) begin
      logic c, l, i; logic [15:0] d; int dly;
      c = ($urandom % 5) == 0; l = ($urandom % 3) == 0; i = ($urandom % 2) == 0;
      d = 16'($urandom);
      pc_cmd(c, l, i, d);
      m_pc = model_pc(m_pc, c, l, i, d);
      check("rnd_pc_idle", 32'(pc), 32'(m_pc));
      start_addr = m_pc;
      fetch_req = 1; tick(); fetch_req = 0;
      check("rnd_addr", 32'(mif.mem_addr), 32'(start_addr));
      dly = int'($urandom % 4);
      for (int k = 0; k < dly; k++) begin
        mif.mem_rdata = 16'($urandom); tick();
        check("rnd_req_hold", {15'd0, mif.mem_req, mif.mem_addr}, {16'd1, start_addr});
      end
      r = 16'($urandom);
      mif.mem_ack = 1; mif.mem_rdata = r; tick(); mif.mem_ack = 0;
      m_cnt++;
      check("rnd_ir", {14'd0, fetch_done, ir_valid, ir}, {16'd3, r});
      check("rnd_cnt", 32'(fetch_cnt), 32'(m_cnt));
      c = ($urandom % 5) == 0; l = ($urandom % 3) == 0; i = ($urandom % 2) == 0;
      d = 16'($urandom);
      pc_cmd(c, l, i, d);
      m_pc = model_pc(m_pc, c, l, i, d);
      check("rnd_pc_done", 32'(pc), 32'(m_pc));
    end

    // PC command during REQ sets sticky err.
    fetch_req = 1; tick(); fetch_req = 0;
    pc_cmd(0, 1, 0, 16'h5555);
    check("err_pc_hold", 32'(pc), 32'(m_pc));
    check("err_set", 32'(err), 1);
    mif.mem_ack = 1; tick(); mif.mem_ack = 0; m_cnt++;
    tick(); tick();
    check("err_sticky", 32'(err), 1);

    // Halt pulsed in REQ: fetch completes, then HALTED.
    fetch_req = 1; tick(); fetch_req = 0;
    halt = 1; tick(); halt = 0;
    tick();
    check("halt_req_hold", 32'(mif.mem_req), 1);
    mif.mem_ack = 1; mif.mem_rdata = 16'h0F25; tick(); mif.mem_ack = 0; m_cnt++;
    check("halt_done", 32'(fetch_done), 1);
    check("halt_not_yet", 32'(halted), 0);
    tick();
    check("halt_halted", {29'd0, halted, busy, fetch_done}, 32'b100);
    fetch_req = 1; pc_inc = 1; mif.mem_ack = 1; tick(); tick();
    fetch_req = 0; pc_inc = 0; mif.mem_ack = 0;
    check("halt_no_req", 32'(mif.mem_req), 0);
    check("halt_pc_ign", 32'(pc), 32'(m_pc));
    check("halt_cnt", 32'(fetch_cnt), 32'(m_cnt));
    check("halt_ir", 32'(ir), 32'h0F25);

    // Reset mid-REQ, then a late ack.
    rst_n = 0; tick(); rst_n = 1; tick();
    fetch_req = 1; pc_inc = 1; tick(); fetch_req = 0; pc_inc = 0;
    check("mid_in_req", 32'(mif.mem_req), 1);
    rst_n = 0; #2;
    check("mid_rst_req", 32'(mif.mem_req), 0);
    check("mid_rst_status", {28'd0, fetch_done, busy, halted, err}, 0);
    check("mid_rst_pc", 32'(pc), 0);
    check("mid_rst_cnt", 32'(fetch_cnt), 0);
    check("mid_rst_addr", 32'(mif.mem_addr), 0);
    tick();
    rst_n = 1; mif.mem_ack = 1; mif.mem_rdata = 16'hBEEF; tick(); mif.mem_ack = 0;
    tick();
    check("late_ack_cnt", 32'(fetch_cnt), 0);
    check("late_ack_ir", {15'd0, ir_valid, ir}, 0);
    check("late_ack_busy", 32'(busy), 0);

    // halt and fetch_req together in IDLE: halt wins.
    halt = 1; fetch_req = 1; tick(); halt = 0; fetch_req = 0;
    check("hf_halted", 32'(halted), 1);
    check("hf_no_req", 32'(mif.mem_req), 0);
    tick();
    check("hf_no_req2", 32'(mif.mem_req), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/punc_fetch.md
# punc_fetch

Instruction-fetch stage for the PUnC LC3 processor, sitting directly upstream of the control unit. It owns the program counter and instruction register, issues instruction reads to memory over a request/acknowledge handshake that tolerates variable latency, and presents the fetched instruction word (`ir`) to the control unit. It also applies the control unit's PC clear, increment and load commands, and counts completed fetches.

## Interface
- `RESET_PC`, 16'h0000: PC value after reset and after `pc_clr`.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `fetch_req`  in  1: start a fetch at the current PC; honoured only in IDLE.
- `halt`  in  1: enter HALTED. Takes effect after any outstanding fetch completes.
- `pc_clr`  in  1: PC <= `RESET_PC`.
- `pc_ld`  in  1: PC <= `pc_ld_data`.
- `pc_ld_data`  in  16: PC load value.
- `pc_inc`  in  1: PC <= PC + 1.
- `mem_req`  out  1: memory read request; held until acknowledged.
- `mem_addr`  out  16: read address; stable while `mem_req` is high.
- `mem_ack`  in  1: read data valid this cycle.
- `mem_rdata`  in  16: read data.
- `ir`  out  16: instruction register.
- `ir_valid`  out  1: `ir` holds the result of the most recent fetch.
- `fetch_done`  out  1: one-cycle pulse when a fetch completes.
- `pc`  out  16: program counter.
- `busy`  out  1: high in REQ and DONE.
- `halted`  out  1: high in HALTED.
- `fetch_cnt`  out  16: completed fetches; saturates at 16'hFFFF.
- `err`  out  1: sticky flag for a PC command issued while in REQ.

## Operation
- States:
  - IDLE (0)
  - REQ (1)
  - DONE (2)
  - HALTED (3)
- IDLE:
  - `fetch_req` -> REQ. `mem_addr` <= `pc`, `ir_valid` <= 0.
  - `halt` -> HALTED. If `halt` and `fetch_req` are both high, `halt` wins and no fetch starts.
- REQ:
  - `mem_req` = 1.
  - On `mem_ack`: `ir` <= `mem_rdata`, `ir_valid` <= 1, increment `fetch_cnt` (saturating), go to DONE.
  - Without `mem_ack`: stay in REQ.
  - `halt` seen in REQ is latched into a pending flag.
- DONE:
  - `fetch_done` = 1 for exactly one cycle.
  - Next state is HALTED if `halt` is high now or the pending flag is set (flag cleared); otherwise IDLE.
- HALTED: terminal. Only `rst_n` exits. All inputs are ignored; `mem_req` = 0.
- PC commands:
  - Accepted in IDLE and DONE. Priority is `pc_clr` > `pc_ld` > `pc_inc`; at most one is applied per cycle.
  - Increment wraps: 16'hFFFF -> 16'h0000.
  - In REQ, any PC command is ignored, PC is unchanged and `err` <= 1.
  - In HALTED, PC commands are ignored silently.
- `mem_addr` is a register. It changes only on entry to REQ.
- Reset values:
  - state = IDLE
  - `pc` = `RESET_PC`
  - `ir` = 0, `ir_valid` = 0
  - `mem_req` = 0, `mem_addr` = 0
  - `fetch_done` = 0, `busy` = 0, `halted` = 0
  - `fetch_cnt` = 0, `err` = 0
  - pending-halt flag = 0
- Reset mid-fetch: all state returns to reset values asynchronously. A late `mem_ack` arriving after reset, while in IDLE, is ignored.
- `mem_ack` outside REQ is ignored.

## Timing
- `fetch_req` sampled at edge t: `mem_req` = 1 and `mem_addr` = PC from cycle t+1.
- `mem_ack` sampled at edge t+k (k >= 1): `ir`/`ir_valid` updated and `fetch_done` = 1 in cycle t+k+1. `mem_req` drops in the same cycle.
- Minimum `fetch_req` -> `fetch_done` latency is 2 cycles (ack on the first REQ cycle). Minimum back-to-back fetch period is 3 cycles.
- PC commands take effect at the sampling edge; the new `pc` is visible the following cycle.
- `mem_req`, `mem_addr`, `ir`, `fetch_done`, `busy`, `halted` are all registered or decoded from state only. There are no combinational paths from inputs.

## Test plan
- Reset release, then `fetch_req` with `mem_ack` on the first REQ cycle and `mem_rdata` = 16'h1261 -> `mem_addr` = 0; `ir` = 16'h1261 and `fetch_done` pulse 2 cycles after req; `fetch_cnt` = 1.
- Ack delayed 5 cycles, with `mem_rdata` toggling before ack -> `mem_req` high for 6 cycles, `mem_addr` stable; `ir` captures only the value present at ack.
- PC commands:
  - PC = 16'hFFFF, `pc_inc` -> 16'h0000.
  - `pc_clr` + `pc_ld` (16'h3000) + `pc_inc` in the same cycle -> `RESET_PC`.
  - `pc_ld` + `pc_inc` -> 16'h3000.
- `pc_ld` during REQ -> PC unchanged, `err` = 1 and stays 1 until `rst_n` low.
- `halt` pulsed in REQ -> fetch completes, `fetch_done` pulses, then HALTED. A subsequent `fetch_req` produces no `mem_req`.
- `rst_n` asserted mid-REQ -> outputs return to reset values immediately. An ack after release has no effect; `fetch_cnt` = 0.
